// File: rtl/dmem_access_pkg.sv
// Shared op encodings, FSM states and default geometry for the DMEM load/store sequencer.
package dmem_access_pkg;

    localparam logic [31:0] ADDR_BASE_DEF   = 32'h1001_0000;
    localparam int          DEPTH_WORDS_DEF = 32;
    localparam int          DM_AW_DEF       = 11;
    localparam int          DATA_W          = 32;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    function automatic logic op_is_load(input op_e op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_lane_unit.sv
// Little-endian lane handling: extends load data and merges sub-word stores into a read word.
module dmem_lane_unit
    import dmem_access_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_lane,
    input  op_e         i_op,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_lane)
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

        o_load = i_word;
        case (i_op)
            OP_LH:   o_load = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_load = {16'h0000, w_half};
            OP_LB:   o_load = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_load = {24'h000000, w_byte};
            default: o_load = i_word;
        endcase

        // Only the addressed lane is replaced; the rest comes from the word read in RD.
        o_merged = i_word;
        case (i_op)
            OP_SB: begin
                case (i_lane)
                    2'd0:    o_merged[7:0]   = i_wdata[7:0];
                    2'd1:    o_merged[15:8]  = i_wdata[7:0];
                    2'd2:    o_merged[23:16] = i_wdata[7:0];
                    default: o_merged[31:24] = i_wdata[7:0];
                endcase
            end
            OP_SH: begin
                if (i_lane[1]) o_merged[31:16] = i_wdata[15:0];
                else           o_merged[15:0]  = i_wdata[15:0];
            end
            OP_SW:   o_merged = i_wdata;
            default: o_merged = i_word;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer between the CPU memory stage and DMEM: range/alignment check,
// read-modify-write for sub-word stores, extended load data on the response channel.
//
// state | meaning
// IDLE  | ready for a request; dm_* all low
// RD    | DMEM read of the target word (loads and SB/SH)
// WR    | single-cycle DMEM write strobe, commits at negedge
// RESP  | response held until resp_ready
module dmem_access_ctrl
    import dmem_access_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEF,
    parameter int          DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int          DM_AW       = DM_AW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_rdata,
    output logic             resp_err,
    output logic             dm_ena,
    output logic             dm_read,
    output logic             dm_write,
    output logic [DM_AW-1:0] dm_addr,
    output logic [31:0]      dm_wdata,
    input  logic [31:0]      dm_rdata
);

    localparam logic [31:0] LP_LIMIT = 32'(DEPTH_WORDS) << 2;

    state_e           r_state, w_next;
    op_e              r_op;
    logic [DM_AW-1:0] r_widx;
    logic [1:0]       r_lane;
    logic [31:0]      r_wdata;
    logic [31:0]      r_resp_rdata;
    logic             r_resp_err;

    op_e         w_req_op;
    logic [31:0] w_off;
    logic        w_align_err;
    logic        w_err;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    assign w_req_op = op_e'(req_op);
    assign w_off    = req_addr - ADDR_BASE;

    always_comb begin
        w_align_err = 1'b1;
        case (w_req_op)
            OP_LW, OP_SW:         w_align_err = (req_addr[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: w_align_err = req_addr[0];
            OP_LB, OP_LBU, OP_SB: w_align_err = 1'b0;
            default:              w_align_err = 1'b1;
        endcase
    end

    assign w_err = (w_off >= LP_LIMIT) || w_align_err;

    dmem_lane_unit u_lane (
        .i_word   (dm_rdata),
        .i_wdata  (r_wdata),
        .i_lane   (r_lane),
        .i_op     (r_op),
        .o_load   (w_load),
        .o_merged (w_merged)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_err)                 w_next = ST_RESP;
                    else if (w_req_op == OP_SW) w_next = ST_WR;
                    else                       w_next = ST_RD;
                end
            end
            ST_RD:   w_next = op_is_load(r_op) ? ST_RESP : ST_WR;
            ST_WR:   w_next = ST_RESP;
            ST_RESP: if (resp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_op         <= OP_LW;
            r_widx       <= '0;
            r_lane       <= 2'b00;
            r_wdata      <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && req_valid) begin
                r_op         <= w_req_op;
                r_widx       <= w_off[DM_AW+1:2];
                r_lane       <= req_addr[1:0];
                r_wdata      <= req_wdata;
                r_resp_rdata <= '0;
                r_resp_err   <= w_err;
            end
            // dm_rdata is only meaningful while the read strobe is up.
            if (r_state == ST_RD) begin
                if (op_is_load(r_op)) r_resp_rdata <= w_load;
                else                  r_wdata      <= w_merged;
            end
        end
    end

    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign dm_read    = (r_state == ST_RD);
    assign dm_write   = (r_state == ST_WR);
    assign dm_ena     = dm_read || dm_write;
    assign dm_addr    = dm_ena ? r_widx : '0;
    assign dm_wdata   = dm_write ? r_wdata : '0;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: behavioural DMEM plus a scoreboard of expected responses.
module tb_dmem_access_ctrl;
    import dmem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        dm_ena, dm_read, dm_write;
    logic [10:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    logic [31:0] mem [0:31];
    logic        pre_en = 1'b0;
    logic [4:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          n_rd;
        int          n_wr;
        logic [10:0] widx;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    dmem_access_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dm_ena     (dm_ena),
        .dm_read    (dm_read),
        .dm_write   (dm_write),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_rdata   (dm_rdata)
    );

    // DMEM floats when not reading; a junk pattern stands in for 'z.
    assign dm_rdata = (dm_ena && dm_read && dm_addr < 11'd32) ? mem[dm_addr[4:0]] : 32'hA5A5_5A5A;

    always @(negedge clk) begin
        if (pre_en)
            mem[pre_idx] = pre_val;
        else if (dm_ena && dm_write && dm_addr < 11'd32)
            mem[dm_addr[4:0]] = dm_wdata;
    end

    task automatic preload(input logic [4:0] idx, input logic [31:0] val);
        @(posedge clk); #1;
        pre_idx = idx; pre_val = val; pre_en = 1'b1;
        @(negedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic run_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                           input int exp_rd, input int exp_wr, input logic [10:0] exp_widx,
                           input int stall);
        exp_t e;
        int   lat, nrd, nwr, proto;
        bit   done;
        e = '{rdata: exp_rdata, err: exp_err, lat: exp_lat, n_rd: exp_rd, n_wr: exp_wr, widx: exp_widx};
        sb_q.push_back(e);
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL accept_ready op=%0d addr=%h: req_ready=%b required 1", op, addr, req_ready);
            void'(sb_q.pop_front());
            return;
        end
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 3'd0; req_addr = '0; req_wdata = '0;
        lat = 0; nrd = 0; nwr = 0; proto = 0; done = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (dm_ena && dm_read)  nrd++;
            if (dm_ena && dm_write) nwr++;
            if (dm_read && dm_write) proto++;
            if (dm_ena && dm_addr !== e.widx) proto++;
            if (resp_valid) done = 1;
        end
        e = sb_q.pop_front();
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL resp_timeout addr=%h: no resp_valid within %0d cycles", addr, lat);
        end
        n_cmp++;
        if (lat !== e.lat) begin
            n_bad++; $display("FAIL latency addr=%h: got %0d required %0d", addr, lat, e.lat);
        end
        n_cmp++;
        if (resp_rdata !== e.rdata) begin
            n_bad++; $display("FAIL rdata addr=%h: got %h required %h", addr, resp_rdata, e.rdata);
        end
        n_cmp++;
        if (resp_err !== e.err) begin
            n_bad++; $display("FAIL err addr=%h: got %b required %b", addr, resp_err, e.err);
        end
        n_cmp++;
        if (nrd !== e.n_rd || nwr !== e.n_wr) begin
            n_bad++;
            $display("FAIL dm_strobes addr=%h: reads %0d writes %0d required %0d/%0d", addr, nrd, nwr, e.n_rd, e.n_wr);
        end
        n_cmp++;
        if (proto !== 0 || dm_ena !== 1'b0 || dm_addr !== 11'd0 || dm_wdata !== 32'd0) begin
            n_bad++;
            $display("FAIL dm_protocol addr=%h: bad cycles %0d, dm_ena in RESP %b required 0", addr, proto, dm_ena);
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            n_cmp++;
            if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || resp_err !== e.err || req_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_hold cycle %0d: valid=%b rdata=%h ready=%b required 1/%h/0",
                         s, resp_valid, resp_rdata, req_ready, e.rdata);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        n_cmp++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL handshake_idle: resp_valid=%b req_ready=%b required 0/1", resp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_resp: ready=%b valid=%b rdata=%h err=%b required 1/0/0/0",
                     req_ready, resp_valid, resp_rdata, resp_err);
        end
        n_cmp++;
        if (dm_ena !== 1'b0 || dm_read !== 1'b0 || dm_write !== 1'b0 || dm_addr !== 11'd0 || dm_wdata !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_dm: ena=%b rd=%b wr=%b addr=%h wdata=%h required all 0",
                     dm_ena, dm_read, dm_write, dm_addr, dm_wdata);
        end
    endtask

    task automatic test_sw_lw();
        run_req(OP_SW, 32'h1001_0008, 32'hDEAD_BEEF, 32'd0, 1'b0, 2, 0, 1, 11'd2, 0);
        n_cmp++;
        if (mem[2] !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL sw_commit: word2=%h required deadbeef", mem[2]);
        end
        run_req(OP_LW, 32'h1001_0008, 32'd0, 32'hDEAD_BEEF, 1'b0, 2, 1, 0, 11'd2, 0);
    endtask

    task automatic test_sub_word();
        run_req(OP_SB, 32'h1001_0009, 32'h0000_0012, 32'd0, 1'b0, 3, 1, 1, 11'd2, 0);
        n_cmp++;
        if (mem[2] !== 32'hDEAD_12EF) begin
            n_bad++; $display("FAIL sb_merge: word2=%h required dead12ef", mem[2]);
        end
        run_req(OP_LB,  32'h1001_000B, 32'd0, 32'hFFFF_FFDE, 1'b0, 2, 1, 0, 11'd2, 0);
        run_req(OP_LBU, 32'h1001_000B, 32'd0, 32'h0000_00DE, 1'b0, 2, 1, 0, 11'd2, 0);
        preload(5'd0, 32'h1122_3344);
        run_req(OP_SH, 32'h1001_0002, 32'h7777_ABCD, 32'd0, 1'b0, 3, 1, 1, 11'd0, 0);
        n_cmp++;
        if (mem[0] !== 32'hABCD_3344) begin
            n_bad++; $display("FAIL sh_merge: word0=%h required abcd3344", mem[0]);
        end
    endtask

    task automatic test_stall();
        run_req(OP_LW, 32'h1001_0008, 32'd0, 32'hDEAD_12EF, 1'b0, 2, 1, 0, 11'd2, 5);
    endtask

    task automatic test_half();
        preload(5'd2, 32'h8001_0000);
        run_req(OP_LH,  32'h1001_000A, 32'd0, 32'hFFFF_8001, 1'b0, 2, 1, 0, 11'd2, 0);
        run_req(OP_LHU, 32'h1001_000A, 32'd0, 32'h0000_8001, 1'b0, 2, 1, 0, 11'd2, 0);
        run_req(OP_LH,  32'h1001_0009, 32'd0, 32'd0,         1'b1, 1, 0, 0, 11'd0, 0);
    endtask

    task automatic test_range();
        preload(5'd31, 32'h0BAD_F00D);
        run_req(OP_LW, 32'h1001_007C, 32'd0, 32'h0BAD_F00D, 1'b0, 2, 1, 0, 11'd31, 0);
        run_req(OP_LW, 32'h1001_0080, 32'd0, 32'd0, 1'b1, 1, 0, 0, 11'd0, 0);
        run_req(OP_LW, 32'h1000_FFFC, 32'd0, 32'd0, 1'b1, 1, 0, 0, 11'd0, 0);
        run_req(OP_SW, 32'h1001_0006, 32'h1234_5678, 32'd0, 1'b1, 1, 0, 0, 11'd0, 0);
        run_req(OP_SH, 32'h1001_0001, 32'h0000_5678, 32'd0, 1'b1, 1, 0, 0, 11'd0, 0);
        n_cmp++;
        if (mem[1] !== 32'h0000_0000 && mem[1] !== 32'hxxxx_xxxx) begin
            n_bad++; $display("FAIL err_no_write: word1=%h required untouched", mem[1]);
        end
    endtask

    task automatic test_back_to_back();
        preload(5'd4, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++)
            run_req(OP_SB, 32'h1001_0010 + 32'(i), 32'h5555_5500 | 32'(8'hA0 + i),
                    32'd0, 1'b0, 3, 1, 1, 11'd4, 0);
        run_req(OP_LW,  32'h1001_0010, 32'd0, 32'hA3A2_A1A0, 1'b0, 2, 1, 0, 11'd4, 0);
        run_req(OP_LH,  32'h1001_0012, 32'd0, 32'hFFFF_A3A2, 1'b0, 2, 1, 0, 11'd4, 0);
        run_req(OP_LHU, 32'h1001_0010, 32'd0, 32'h0000_A1A0, 1'b0, 2, 1, 0, 11'd4, 0);
    endtask

    task automatic test_reset_in_wr();
        preload(5'd5, 32'h0000_0055);
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h1001_0014; req_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_cmp++;
        if (dm_write !== 1'b1) begin
            n_bad++; $display("FAIL wr_reached: dm_write=%b required 1", dm_write);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (dm_write !== 1'b0 || dm_ena !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_in_wr: dm_write=%b dm_ena=%b ready=%b valid=%b required 0/0/1/0",
                     dm_write, dm_ena, req_ready, resp_valid);
        end
        @(negedge clk); #1;
        n_cmp++;
        if (mem[5] !== 32'h0000_0055) begin
            n_bad++; $display("FAIL rst_lost_write: word5=%h required 00000055", mem[5]);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_sw_lw();
        test_sub_word();
        test_stall();
        test_half();
        test_range();
        test_back_to_back();
        test_reset_in_wr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
